rotl_seq: RTL
=============

Name: rotl_seq

Overview:
- Sequential rotate-left unit; the inverse of the team's combinational rotate-right barrel shifter.
- Accepts a data word and a rotate amount over a valid/ready handshake.
- Rotates the word left one position per clock, then holds the result until the consumer takes it.
- Used on the receive side of datapaths whose transmit side applied a right rotation: rotl_seq(rotr(q,s),s) == q.

Parameters:
- WIDTH, 4, data word width in bits (>= 2).
- AMTW, $clog2(WIDTH), width of the rotate-amount field.

Ports:
- clk  input  1  clock, all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a word and amount on in_data/in_amt
- in_ready  output  1  block can accept; high only in IDLE
- in_data  input  WIDTH  word to rotate
- in_amt  input  AMTW  rotate-left amount, 0..WIDTH-1
- out_valid  output  1  result on out_data is valid; high only in DONE
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  rotated word (registered)
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE, data reg=0, count=0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, busy=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready (accept edge E0): data<=in_data, count<=in_amt.
  - Next state is DONE if in_amt==0, else SHIFT.
- SHIFT, each edge:
  - data<={data[WIDTH-2:0],data[WIDTH-1]}; count<=count-1.
  - When count==1 on that edge, next state is DONE.
- Latency: out_valid rises on edge E0+in_amt. amt=0 means the result is visible one cycle after accept; amt=k takes k edges.
- DONE:
  - out_valid=1; out_data=data, held stable while out_ready=0 (no limit on stall length).
  - On an edge with out_ready=1: next state is IDLE and out_valid drops. out_data keeps its last value until the next result.
- No accept in the same cycle as result handoff. Minimum spacing between accepts is in_amt+2 cycles.
- in_valid outside IDLE is ignored. The producer must hold in_data/in_amt until accepted.
- in_amt is unsigned, interpreted modulo WIDTH. A non-power-of-2 WIDTH with in_amt>=WIDTH rotates by in_amt mod WIDTH; the count is pre-reduced at accept.
- Reset mid-SHIFT or mid-DONE: the operation is abandoned, all state returns to reset values, and no out_valid pulse is produced.
- out_ready asserted while not in DONE has no effect.

Decomposition:
- Package rotl_pkg:
  - state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - Helper function rotl1(word) for the single-position rotate.
- No sub-module needed. The one-bit rotate is a function, not an instance. Datapath and FSM stay in one module.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> immediately in_ready=1, out_valid=0, out_data=0, busy=0.
- amt=0: in_data=4'hA, in_amt=0 -> out_valid on E0+1 cycle, out_data=4'hA.
- Inverse check against the rotate-right mapping (sel=1 maps 4'b1011 to 4'b1101): in_data=4'b1101, in_amt=1 -> out_data=4'b1011 at E0+1.
- Max rotate: in_data=4'b0001, in_amt=3 -> out_data=4'b1000 at E0+3.
- Backpressure: out_ready=0 for 5 cycles after out_valid, in_valid=1 throughout:
  - out_data stable, in_ready=0, no second accept.
  - Release -> IDLE next edge, then the new word is accepted.
- Reset mid-op and wide variant:
  - WIDTH=4, in_amt=3, drop rst_n after 1 shift -> no out_valid, reset outputs.
  - WIDTH=8, in_data=8'h81, in_amt=5 -> out_data=8'h30 at E0+5.
  - Exhaustive 4-bit sweep of rotl_seq(rotr(q,s),s)==q over all q and s.

Source files
------------

// File: rtl/rotl_pkg.sv
// rtl/rotl_pkg.sv - shared state encoding and single-step rotate helper for rotl_seq
package rotl_pkg;

    localparam int MAXW = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Rotates the low 'width' bits of word left by one; bits at or above width must be zero.
    function automatic logic [MAXW-1:0] rotl1(input logic [MAXW-1:0] word, input int unsigned width);
        logic [MAXW-1:0] mask;
        mask = {MAXW{1'b1}} >> (MAXW - width);
        return ((word << 1) | (word >> (width - 1))) & mask;
    endfunction

endpackage

// File: rtl/rotl_seq.sv
// rtl/rotl_seq.sv - sequential rotate-left unit, one bit position per clock, valid/ready on both sides
module rotl_seq
    import rotl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMTW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMTW-1:0]  in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_data;
    logic [AMTW-1:0]  r_count;
    logic             w_load;
    logic             w_shift;
    logic [AMTW-1:0]  w_amt_mod;
    logic [WIDTH-1:0] w_rot;

    // Reducing at accept keeps the shift loop a plain down-counter for non-power-of-2 widths.
    assign w_amt_mod = AMTW'(32'(in_amt) % 32'(WIDTH));
    assign w_rot     = WIDTH'(rotl1(MAXW'(r_data), WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_shift = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_load = 1'b1;
                    w_next = (w_amt_mod == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (r_count == AMTW'(1)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_count <= '0;
        end else if (w_load) begin
            r_data  <= in_data;
            r_count <= w_amt_mod;
        end else if (w_shift) begin
            r_data  <= w_rot;
            r_count <= r_count - AMTW'(1);
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_data  = r_data;

endmodule
